// File: rtl/elgamal_pkg.sv
// rtl/elgamal_pkg.sv - shared types and constants for the ElGamal datapath
package elgamal_pkg;

  // Default dividend width of the modular reducer.
  localparam int SIZE_DEF = 32;

  // Reducer FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor. It is kept wide enough for any
  // supported SIZE; users truncate it to their own width.
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mod_reduce_32_if.sv
// rtl/mod_reduce_32_if.sv - operand and result streams of the modular reducer
interface mod_reduce_32_if #(
  parameter int SIZE = 32
);

  localparam int HALF = SIZE / 2;

  // Dividend (product) stream.
  logic [SIZE-1:0] input_a_tdata;
  logic            input_a_tvalid;
  logic            input_a_tready;

  // Divisor (modulus) stream.
  logic [HALF-1:0] input_b_tdata;
  logic            input_b_tvalid;
  logic            input_b_tready;

  // Result stream: remainder, quotient and divide-by-zero flag.
  logic [HALF-1:0] output_tdata;
  logic [SIZE-1:0] output_quot_tdata;
  logic            output_tuser;
  logic            output_tvalid;
  logic            output_tready;

  // Reducer side.
  modport slave (
    input  input_a_tdata, input_a_tvalid,
    output input_a_tready,
    input  input_b_tdata, input_b_tvalid,
    output input_b_tready,
    output output_tdata, output_quot_tdata, output_tuser, output_tvalid,
    input  output_tready
  );

  // Producer/consumer side.
  modport master (
    output input_a_tdata, input_a_tvalid,
    input  input_a_tready,
    output input_b_tdata, input_b_tvalid,
    input  input_b_tready,
    input  output_tdata, output_quot_tdata, output_tuser, output_tvalid,
    output output_tready
  );

endinterface

// File: rtl/mod_reduce_32_div_step.sv
// rtl/mod_reduce_32_div_step.sv - one restoring-division step
module div_step #(
  parameter int HALF = 16
) (
  input  logic [HALF:0]   r_i,
  input  logic            msb_i,
  input  logic [HALF-1:0] divisor_i,
  output logic [HALF:0]   r_o,
  output logic            q_bit_o
);

  logic [HALF:0] r_next;
  logic [HALF:0] dvs_ext;

  // Shift the next dividend bit into the partial remainder and subtract the
  // divisor when it fits. The extra top bit keeps the compare exact when the
  // shifted remainder overflows HALF bits.
  always_comb begin
    r_next  = (HALF+1)'({r_i, msb_i});
    dvs_ext = {1'b0, divisor_i};
    q_bit_o = (r_next >= dvs_ext);
    r_o     = q_bit_o ? (r_next - dvs_ext) : r_next;
  end

endmodule

// File: rtl/mod_reduce_32.sv
// rtl/mod_reduce_32.sv - iterative restoring divider returning quotient and remainder
module mod_reduce_32
  import elgamal_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input logic          clk,
  input logic          rst,
  mod_reduce_32_if.slave bus
);

  localparam int HALF = SIZE / 2;
  localparam int CW   = $clog2(SIZE);

  state_t          state_q, state_d;
  logic [SIZE-1:0] dvd_q, dvd_d;
  logic [HALF-1:0] dvs_q, dvs_d;
  logic [HALF:0]   r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] quot_q, quot_d;
  logic [HALF-1:0] rem_q, rem_d;
  logic            tuser_q, tuser_d;
  logic            tvalid_q, tvalid_d;

  logic            accept;
  logic            div_zero;
  logic [HALF:0]   step_r;
  logic            step_q;

  div_step #(.HALF(HALF)) u_step (
    .r_i       (r_q),
    .msb_i     (dvd_q[SIZE-1]),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_bit_o   (step_q)
  );

  // Both operands are taken together, and only while idle.
  always_comb begin
    bus.input_a_tready = (state_q == IDLE) && bus.input_b_tvalid;
    bus.input_b_tready = (state_q == IDLE) && bus.input_a_tvalid;
    accept   = (state_q == IDLE) && bus.input_a_tvalid && bus.input_b_tvalid;
    div_zero = (bus.input_b_tdata == '0);
  end

  // Next-state and datapath: load on acceptance, one quotient bit per CALC
  // cycle, hold results in DONE until the consumer takes them.
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    tuser_d  = tuser_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dvd_d = bus.input_a_tdata;
          dvs_d = bus.input_b_tdata;
          r_d   = '0;
          cnt_d = CW'(SIZE - 1);
          if (div_zero) begin
            state_d = DONE;
            quot_d  = SIZE'(DIV0_QUOT);
            rem_d   = bus.input_a_tdata[HALF-1:0];
            tuser_d = 1'b1;
          end else begin
            state_d = CALC;
            quot_d  = '0;
            tuser_d = 1'b0;
          end
        end
      end
      CALC: begin
        dvd_d  = {dvd_q[SIZE-2:0], 1'b0};
        r_d    = step_r;
        quot_d = {quot_q[SIZE-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = DONE;
          rem_d   = step_r[HALF-1:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (bus.output_tready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tvalid_d = (state_d == DONE);
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Result stream comes straight from the registers.
  always_comb begin
    bus.output_tdata      = rem_q;
    bus.output_quot_tdata = quot_q;
    bus.output_tuser      = tuser_q;
    bus.output_tvalid     = tvalid_q;
  end

endmodule

// File: tb/tb_mod_reduce_32.sv
// tb/tb_mod_reduce_32.sv - directed self-checking bench for mod_reduce_32
module tb_mod_reduce_32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mod_reduce_32_if #(.SIZE(32)) bus ();

  mod_reduce_32 #(.SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present both operands and let them be accepted on the next edge.
  task automatic start(input string tag, input logic [31:0] a, input logic [15:0] b);
    bus.input_a_tdata  = a;
    bus.input_b_tdata  = b;
    bus.input_a_tvalid = 1'b1;
    bus.input_b_tvalid = 1'b1;
    #1;
    chk({tag, ".a_tready"}, bus.input_a_tready, 1);
    @(posedge clk);
    #1;
    bus.input_a_tvalid = 1'b0;
    bus.input_b_tvalid = 1'b0;
  endtask

  // n0 = edges already elapsed since the acceptance edge (1 right after it).
  task automatic wait_res(input string tag, input int n0, input int lat,
                          input logic [31:0] q, input logic [15:0] r, input logic u);
    int n;
    n = n0;
    while (!bus.output_tvalid && n < 100) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".quot"}, bus.output_quot_tdata, q);
    chk({tag, ".rem"}, bus.output_tdata, r);
    chk({tag, ".tuser"}, bus.output_tuser, u);
    if (bus.output_tready) begin
      step();
      chk({tag, ".tvalid_drop"}, bus.output_tvalid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1;
    bus.input_a_tdata  = '0;
    bus.input_b_tdata  = '0;
    bus.input_a_tvalid = 1'b0;
    bus.input_b_tvalid = 1'b0;
    bus.output_tready  = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst.rem", bus.output_tdata, 0);
    chk("rst.quot", bus.output_quot_tdata, 0);
    chk("rst.tuser", bus.output_tuser, 0);
    chk("rst.tvalid", bus.output_tvalid, 0);
    chk("rst.a_tready", bus.input_a_tready, 0);

    // Basic reductions.
    start("op1", 32'd1000000, 16'd65521);
    wait_res("op1", 1, 33, 32'd15, 16'd17185, 1'b0);
    start("op2", 32'hFFFFFFFF, 16'hFFFF);
    wait_res("op2", 1, 33, 32'h00010001, 16'd0, 1'b0);
    start("op3", 32'd5, 16'd7);
    wait_res("op3", 1, 33, 32'd0, 16'd5, 1'b0);
    start("op4", 32'hDEADBEEF, 16'd1);
    wait_res("op4", 1, 33, 32'hDEADBEEF, 16'd0, 1'b0);

    // Divide by zero, then a normal op clears tuser.
    start("div0", 32'h12345678, 16'd0);
    wait_res("div0", 1, 1, 32'hFFFFFFFF, 16'h5678, 1'b1);
    start("op5", 32'd1000, 16'd3);
    wait_res("op5", 1, 33, 32'd333, 16'd1, 1'b0);

    // Only the dividend valid: nothing accepted.
    bus.input_a_tdata  = 32'd50000;
    bus.input_b_tdata  = 16'd9;
    bus.input_a_tvalid = 1'b1;
    repeat (5) begin
      step();
      chk("hs.a_only.a_tready", bus.input_a_tready, 0);
      chk("hs.a_only.b_tready", bus.input_b_tready, 1);
    end
    bus.input_b_tvalid = 1'b1;
    #1;
    chk("hs.both.a_tready", bus.input_a_tready, 1);
    @(posedge clk);
    #1;
    // Toggle valids with junk data while calculating.
    for (int i = 0; i < 6; i++) begin
      bus.input_a_tvalid = i[0];
      bus.input_b_tvalid = i[0];
      bus.input_a_tdata  = 32'h0000FFFF;
      bus.input_b_tdata  = 16'd1;
      #2;
      chk("hs.calc.a_tready", bus.input_a_tready, 0);
      chk("hs.calc.b_tready", bus.input_b_tready, 0);
      @(posedge clk);
      #1;
    end
    bus.input_a_tvalid = 1'b0;
    bus.input_b_tvalid = 1'b0;
    wait_res("hs", 7, 33, 32'd5555, 16'd5, 1'b0);

    // Backpressure with the next operation already offered.
    bus.output_tready = 1'b0;
    start("bp", 32'd77777, 16'd100);
    wait_res("bp", 1, 33, 32'd777, 16'd77, 1'b0);
    bus.input_a_tdata  = 32'd100;
    bus.input_b_tdata  = 16'd7;
    bus.input_a_tvalid = 1'b1;
    bus.input_b_tvalid = 1'b1;
    repeat (10) begin
      step();
      chk("bp.hold.quot", bus.output_quot_tdata, 777);
      chk("bp.hold.rem", bus.output_tdata, 77);
      chk("bp.hold.tuser", bus.output_tuser, 0);
      chk("bp.hold.tvalid", bus.output_tvalid, 1);
      chk("bp.hold.a_tready", bus.input_a_tready, 0);
    end
    bus.output_tready = 1'b1;
    step();
    chk("bp.release.tvalid", bus.output_tvalid, 0);
    chk("bp.release.idle_a_tready", bus.input_a_tready, 1);
    @(posedge clk);
    #1;
    bus.input_a_tvalid = 1'b0;
    bus.input_b_tvalid = 1'b0;
    wait_res("bp.next", 1, 33, 32'd14, 16'd2, 1'b0);

    // Reset in the middle of a calculation.
    start("mid", 32'd1000000, 16'd65521);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid.rem", bus.output_tdata, 0);
    chk("mid.quot", bus.output_quot_tdata, 0);
    chk("mid.tuser", bus.output_tuser, 0);
    chk("mid.tvalid", bus.output_tvalid, 0);
    seen = 0;
    repeat (45) begin
      step();
      if (bus.output_tvalid) seen++;
    end
    chk("mid.no_result", seen, 0);
    start("post", 32'd100, 16'd7);
    wait_res("post", 1, 33, 32'd14, 16'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_reduce_32.md
Name: mod_reduce_32

Overview:
- Iterative restoring divider that consumes a full-width product and a half-width modulus on AXI-stream inputs.
- Returns the quotient and remainder (product mod modulus) on an AXI-stream output.
- Sits directly downstream of the 16x16 multiplier in the ElGamal datapath and closes the modular-multiply loop (a*b mod p).
- Produces one quotient bit per clock.

Parameters:
SIZE, 32, dividend/quotient width; divisor/remainder width is SIZE/2 (must be even, >= 4).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active high
input_a_tdata  input  SIZE  dividend (product)
input_a_tvalid  input  1  dividend valid
input_a_tready  output  1  dividend accepted when high with tvalid
input_b_tdata  input  SIZE/2  divisor (modulus)
input_b_tvalid  input  1  divisor valid
input_b_tready  output  1  divisor accepted when high with tvalid
output_tdata  output  SIZE/2  remainder
output_quot_tdata  output  SIZE  quotient
output_tuser  output  1  divide-by-zero flag
output_tvalid  output  1  result valid
output_tready  input  1  downstream ready

Behaviour:
- Reset (synchronous, active high) forces:
  - state = IDLE;
  - output_tdata, output_quot_tdata, output_tuser and output_tvalid = 0;
  - internal dividend shift register, partial remainder, divisor and bit counter = 0.
- Reset asserted mid-operation (CALC or DONE) discards the in-flight operation. No result is ever emitted for it.
- Input handshake:
  - input_a_tready = (state==IDLE) & input_b_tvalid; input_b_tready = (state==IDLE) & input_a_tvalid.
  - Both operands are taken on the same edge, only when both tvalid are high in IDLE. Neither operand is accepted alone.
- FSM IDLE -> CALC:
  - On acceptance, latch dividend into shift register, divisor into divisor register.
  - Clear partial remainder r (width SIZE/2+1) and quotient; set counter = SIZE-1.
- FSM IDLE -> DONE (divide by zero):
  - Taken instead of CALC when accepted divisor == 0.
  - Result: quotient = all ones, remainder = dividend[SIZE/2-1:0], output_tuser = 1.
  - output_tvalid is high 1 cycle after the acceptance edge.
- CALC, every cycle:
  - r_next = {r[SIZE/2-1:0], dividend_msb}; dividend shifts left 1.
  - If r_next >= divisor: r = r_next - divisor and quotient bit = 1. Otherwise r = r_next and quotient bit = 0.
  - Quotient shifts in LSB, so the MSB is resolved first.
  - Counter decrements; at counter==0 the final bit is written and state -> DONE.
- CALC is exactly SIZE cycles. output_tvalid rises SIZE+1 cycles after the acceptance edge (33 for default).
- DONE:
  - output_tvalid = 1; output_tdata, output_quot_tdata and output_tuser are held stable until output_tready is high.
  - On the output handshake edge: state -> IDLE and output_tvalid -> 0.
  - Data registers keep their last value. output_tuser clears on the next acceptance.
- Back-to-back: no input acceptance on the same edge as the output handshake. There is a one-cycle IDLE bubble; throughput is 1 result per SIZE+2 cycles minimum.
- In CALC/DONE, input tready stays low regardless of input tvalid. Upstream data is held by the upstream source, not buffered here.
- Width rules:
  - Remainder is always < divisor, so it fits SIZE/2 bits.
  - The SIZE/2+1-bit r prevents compare overflow when r_next's top bit is set.
  - Quotient is full SIZE bits (divisor 1 yields the whole dividend).
- output_tready high while not in DONE has no effect.

Decomposition:
- Shared package elgamal_pkg holds:
  - SIZE default;
  - FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - DIV0_QUOT constant (all ones).
- One combinational sub-module, div_step: inputs r, dividend_msb, divisor; outputs r_out and q_bit. It is reused later by a pipelined variant.
- FSM, counter and handshake remain in mod_reduce_32.

Test Plan:
- Dividend 32'd1000000, divisor 16'd65521, output_tready=1 -> quot 15, rem 17185, tuser 0. output_tvalid first high exactly 33 cycles after acceptance edge.
- Dividend 32'hFFFFFFFF, divisor 16'hFFFF -> quot 32'h00010001, rem 0. Then 32'd5 / 16'd7 -> quot 0, rem 5. Then 32'hDEADBEEF / 16'd1 -> quot 32'hDEADBEEF, rem 0.
- Dividend 32'h12345678, divisor 0 -> quot 32'hFFFFFFFF, rem 16'h5678, tuser 1. output_tvalid high 1 cycle after acceptance; next normal op shows tuser 0.
- Handshake:
  - Only input_a_tvalid high for 5 cycles -> no acceptance; input_b_tready high, input_a_tready low.
  - Then raise input_b_tvalid -> both accepted on that edge.
  - During CALC, toggling both tvalid -> tready stays 0, no second capture.
- Backpressure: hold output_tready low 10 cycles after output_tvalid rises -> all output fields stable and input tready low throughout. Release -> tvalid drops the next cycle, and the next acceptance occurs no earlier than 1 cycle later.
- Reset mid-op: assert rst for 1 cycle at CALC cycle 10 of 1000000/65521 -> all outputs 0 next cycle and no result emitted. Then 32'd100/16'd7 -> quot 14, rem 2.
